// File: rtl/amstrad_mem_pkg.sv
// amstrad_mem_pkg
// Shared definitions for the Amstrad memory arbiter: arbiter FSM state
// type, SDRAM byte-enable encodings, default parameter values and a
// helper that maps a CPU byte address bit onto a byte-enable lane.
package amstrad_mem_pkg;

    localparam int AW_DEFAULT       = 23;
    localparam int VID_PRIO_DEFAULT = 1;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_VID_ACC = 2'd2
    } arb_state_t;

    // CPU accesses are byte wide; address bit 0 picks the half of the word.
    function automatic logic [1:0] cpu_be(input logic a0);
        return a0 ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/amstrad_req_latch.sv
// amstrad_req_latch
// Holds one requestor's pending access: a capture pulse stores the
// payload and raises pend; clear drops pend once the access is done.
// A capture arriving while pend is still set is discarded and sets the
// sticky ovf flag.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   capture         request event (one cycle)
//   clear           access for the held request has completed
//   data_in         payload sampled on capture
//   pend            request held and not yet completed
//   data            held payload
//   ovf             sticky: a request was lost while one was pending
module amstrad_req_latch
    import amstrad_mem_pkg::*;
#(
    parameter int W = AW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         capture,
    input  logic         clear,
    input  logic [W-1:0] data_in,
    output logic         pend,
    output logic [W-1:0] data,
    output logic         ovf
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            data <= '0;
            ovf  <= 1'b0;
        end else begin
            if (capture && pend) begin
                ovf <= 1'b1;
            end
            if (capture && !pend) begin
                pend <= 1'b1;
                data <= data_in;
            end else if (clear) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/amstrad_mem_arb.sv
// amstrad_mem_arb
// Arbitrates the Z80 CPU and the video fetcher onto a single SDRAM
// controller port. One access is in flight at a time; grants are made
// only from IDLE, and with both requests pending VID_PRIO picks the
// winner while the loser stays pending.
// Optional build macro: AMSTRAD_ROM_WP_EN -- CPU writes to the upper half
// of the address space (ROM region) complete without touching memory.
// Ports:
//   CLK, reset_n                      clock, async active-low reset
//   cpu_rd, cpu_wr, cpu_A, cpu_dout   CPU strobes (level), address, write data
//   cpu_din, cpu_wait                 CPU read data, Z80 WAIT (high = stall)
//   vid_req, vid_A                    video fetch pulse and address
//   vid_data, vid_valid, vid_ovf      fetched word, one-cycle strobe, lost-fetch flag
//   mem_req, mem_we, mem_A,
//   mem_dout, mem_be                  SDRAM request side
//   mem_din, mem_ack                  SDRAM read data and completion
//
// state      | meaning
// IDLE       | no access in flight; grant taken here
// CPU_ACC    | CPU access presented to SDRAM, waiting for mem_ack
// VID_ACC    | video fetch presented to SDRAM, waiting for mem_ack
module amstrad_mem_arb
    import amstrad_mem_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int VID_PRIO = VID_PRIO_DEFAULT
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_A,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_din,
    output logic          cpu_wait,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_A,
    output logic [15:0]   vid_data,
    output logic          vid_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_A,
    output logic [7:0]    mem_dout,
    output logic [1:0]    mem_be,
    input  logic [15:0]   mem_din,
    input  logic          mem_ack,
    output logic          vid_ovf
);

    localparam int CW = AW + 9;

    arb_state_t    state;
    logic          strobe, strobe_q, cpu_edge;
    logic [CW-1:0] cpu_cap_in, cpu_cap;
    logic          cpu_pend, vid_pend, cpu_pw;
    logic [7:0]    cpu_pd;
    logic [AW-1:0] cpu_pa, vid_pa;
    logic          idle, grant_cpu, grant_vid, rom_skip;
    logic          clear_cpu, clear_vid;
    logic          cpu_ovf_unused;

    assign strobe     = cpu_rd | cpu_wr;
    assign cpu_edge   = strobe & ~strobe_q;
    assign cpu_cap_in = {cpu_wr, cpu_dout, cpu_A};
    assign {cpu_pw, cpu_pd, cpu_pa} = cpu_cap;

    assign idle      = (state == ST_IDLE);
    assign grant_vid = idle && vid_pend && (!cpu_pend || (VID_PRIO != 0));
    assign grant_cpu = idle && cpu_pend && !grant_vid;

`ifdef AMSTRAD_ROM_WP_EN
    assign rom_skip = cpu_pw & cpu_pa[AW-1];
`else
    assign rom_skip = 1'b0;
`endif

    // Pending stays set for the whole access so a second request during
    // service is seen as an overflow rather than queued behind it.
    assign clear_cpu = ((state == ST_CPU_ACC) && mem_ack) || (grant_cpu && rom_skip);
    assign clear_vid = (state == ST_VID_ACC) && mem_ack;

    amstrad_req_latch #(.W(CW)) u_cpu_latch (
        .clk     (CLK),
        .rst_n   (reset_n),
        .capture (cpu_edge),
        .clear   (clear_cpu),
        .data_in (cpu_cap_in),
        .pend    (cpu_pend),
        .data    (cpu_cap),
        .ovf     (cpu_ovf_unused)
    );

    amstrad_req_latch #(.W(AW)) u_vid_latch (
        .clk     (CLK),
        .rst_n   (reset_n),
        .capture (vid_req),
        .clear   (clear_vid),
        .data_in (vid_A),
        .pend    (vid_pend),
        .data    (vid_pa),
        .ovf     (vid_ovf)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            // A strobe held across reset must not look like a new access.
            strobe_q  <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= BE_NONE;
            mem_A     <= '0;
            mem_dout  <= '0;
            cpu_din   <= '0;
            cpu_wait  <= 1'b0;
            vid_data  <= '0;
            vid_valid <= 1'b0;
        end else begin
            strobe_q  <= strobe;
            vid_valid <= 1'b0;
            if (cpu_edge) begin
                cpu_wait <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (grant_vid) begin
                        state   <= ST_VID_ACC;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        mem_be  <= BE_WORD;
                        mem_A   <= vid_pa;
                    end else if (grant_cpu) begin
                        if (rom_skip) begin
                            cpu_wait <= 1'b0;
                        end else begin
                            state    <= ST_CPU_ACC;
                            mem_req  <= 1'b1;
                            mem_we   <= cpu_pw;
                            mem_be   <= cpu_be(cpu_pa[0]);
                            mem_A    <= cpu_pa;
                            mem_dout <= cpu_pd;
                        end
                    end
                end
                ST_CPU_ACC: begin
                    if (mem_ack) begin
                        state    <= ST_IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        cpu_wait <= 1'b0;
                        if (!mem_we) begin
                            cpu_din <= mem_A[0] ? mem_din[15:8] : mem_din[7:0];
                        end
                    end
                end
                ST_VID_ACC: begin
                    if (mem_ack) begin
                        state     <= ST_IDLE;
                        mem_req   <= 1'b0;
                        vid_data  <= mem_din;
                        vid_valid <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
